// File: rtl/se_column_frame_loader.sv
// rtl/se_column_frame_loader.sv - configuration frame loader for one fabric column
module se_column_frame_loader #(
    parameter int NUM_ROWS      = 4,
    parameter int FRAME_BITS    = 32,
    parameter int MAX_FRAMES    = 20,
    parameter int COLUMN_ID     = 0,
    parameter int STROBE_CYCLES = 2
) (
    input  logic                           CLK,
    input  logic                           reset,
    input  logic                           s_valid,
    output logic                           s_ready,
    input  logic [31:0]                    s_data,
    output logic [NUM_ROWS*FRAME_BITS-1:0] FrameData,
    output logic [MAX_FRAMES-1:0]          FrameStrobe,
    output logic                           busy,
    output logic                           err_frame,
    output logic [15:0]                    frames_done
);

    localparam int RW = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
    localparam int SW = (STROBE_CYCLES > 1) ? $clog2(STROBE_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, LOAD, STROBE, SKIP} state_t;

    state_t                          state_q, state_d;
    logic [4:0]                      idx_q, idx_d;
    logic [RW-1:0]                   row_cnt_q, row_cnt_d;
    logic [SW-1:0]                   strobe_cnt_q, strobe_cnt_d;
    logic [NUM_ROWS*FRAME_BITS-1:0]  frame_data_q, frame_data_d;
    logic [MAX_FRAMES-1:0]           frame_strobe_q, frame_strobe_d;
    logic                            busy_q, busy_d;
    logic                            err_frame_q, err_frame_d;
    logic [15:0]                     frames_done_q, frames_done_d;

    logic accept;
    logic row_last;
    int   row_sel;

    assign s_ready  = !reset && (state_q != STROBE);
    assign accept   = s_valid && s_ready;
    assign row_last = (int'(row_cnt_q) == NUM_ROWS - 1);
    // First data word lands in the top row, last one next to the terminal tile
    assign row_sel  = NUM_ROWS - 1 - int'(row_cnt_q);

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        row_cnt_d     = row_cnt_q;
        strobe_cnt_d  = strobe_cnt_q;
        frame_data_d  = frame_data_q;
        err_frame_d   = err_frame_q;
        frames_done_d = frames_done_q;
        case (state_q)
            IDLE: begin
                if (accept && s_data[31]) begin
                    row_cnt_d = '0;
                    if (s_data[30:24] != 7'(COLUMN_ID)) begin
                        state_d = SKIP;
                    end else if (int'(s_data[4:0]) < MAX_FRAMES) begin
                        idx_d   = s_data[4:0];
                        state_d = LOAD;
                    end else begin
                        err_frame_d = 1'b1;
                        state_d     = SKIP;
                    end
                end
            end
            LOAD: begin
                if (accept) begin
                    frame_data_d[row_sel*FRAME_BITS +: FRAME_BITS] = s_data[FRAME_BITS-1:0];
                    row_cnt_d = row_cnt_q + RW'(1);
                    if (row_last) begin
                        row_cnt_d    = '0;
                        strobe_cnt_d = '0;
                        state_d      = STROBE;
                    end
                end
            end
            STROBE: begin
                strobe_cnt_d = strobe_cnt_q + SW'(1);
                if (int'(strobe_cnt_q) == STROBE_CYCLES - 1) begin
                    strobe_cnt_d = '0;
                    state_d      = IDLE;
                    if (frames_done_q != 16'hFFFF) begin
                        frames_done_d = frames_done_q + 16'd1;
                    end
                end
            end
            SKIP: begin
                if (accept) begin
                    row_cnt_d = row_cnt_q + RW'(1);
                    if (row_last) begin
                        row_cnt_d = '0;
                        state_d   = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Strobe and busy are registered from the next state so they align with it
    always_comb begin
        frame_strobe_d = '0;
        if (state_d == STROBE) begin
            frame_strobe_d = {{(MAX_FRAMES-1){1'b0}}, 1'b1} << idx_d;
        end
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q        <= IDLE;
            idx_q          <= '0;
            row_cnt_q      <= '0;
            strobe_cnt_q   <= '0;
            frame_data_q   <= '0;
            frame_strobe_q <= '0;
            busy_q         <= 1'b0;
            err_frame_q    <= 1'b0;
            frames_done_q  <= '0;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            row_cnt_q      <= row_cnt_d;
            strobe_cnt_q   <= strobe_cnt_d;
            frame_data_q   <= frame_data_d;
            frame_strobe_q <= frame_strobe_d;
            busy_q         <= busy_d;
            err_frame_q    <= err_frame_d;
            frames_done_q  <= frames_done_d;
        end
    end

    assign FrameData   = frame_data_q;
    assign FrameStrobe = frame_strobe_q;
    assign busy        = busy_q;
    assign err_frame   = err_frame_q;
    assign frames_done = frames_done_q;

endmodule

// File: tb/tb_se_column_frame_loader.sv
// tb/tb_se_column_frame_loader.sv - randomized self-checking bench for se_column_frame_loader
module tb_se_column_frame_loader;

    logic         CLK;
    logic         reset;
    logic         s_valid;
    logic         s_ready;
    logic [31:0]  s_data;
    logic [127:0] FrameData;
    logic [19:0]  FrameStrobe;
    logic         busy;
    logic         err_frame;
    logic [15:0]  frames_done;

    se_column_frame_loader dut (
        .CLK         (CLK),
        .reset       (reset),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_data      (s_data),
        .FrameData   (FrameData),
        .FrameStrobe (FrameStrobe),
        .busy        (busy),
        .err_frame   (err_frame),
        .frames_done (frames_done)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] m_rows [4];
    logic        m_err;
    logic [15:0] m_done;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] model_data();
        logic [127:0] v;
        for (int r = 0; r < 4; r++) v[r*32 +: 32] = m_rows[r];
        return v;
    endfunction

    function automatic logic [19:0] onehot(input int idx);
        logic [19:0] v;
        v = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    function automatic void model_reset();
        for (int r = 0; r < 4; r++) m_rows[r] = '0;
        m_err  = 1'b0;
        m_done = '0;
    endfunction

    // Offers one word, optionally after random idle cycles; returns 1ns after the accepting edge
    task automatic push(input logic [31:0] w, input bit bub);
        int n;
        @(negedge CLK);
        if (bub) begin
            repeat ($urandom_range(0, 2)) begin
                s_valid = 1'b0;
                @(negedge CLK);
            end
        end
        s_valid = 1'b1;
        s_data  = w;
        n = 0;
        while (!s_ready && n < 20) begin
            @(negedge CLK);
            n++;
        end
        chk("accept_timeout", {127'd0, n < 20}, 128'd1);
        @(posedge CLK);
        #1;
        s_valid = 1'b0;
    endtask

    task automatic frame(input logic [31:0] hdr, input bit bub, input bit d31);
        logic [31:0] w;
        int          sel;
        int          idx;
        bit          hit;
        bit          ok;
        idx = int'(hdr[4:0]);
        hit = (hdr[30:24] == 7'd0);
        ok  = hit && (idx < 20);
        sel = $urandom_range(0, 3);
        push(hdr, bub);
        if (hit && !ok) m_err = 1'b1;
        chk("busy_after_hdr", {127'd0, busy}, 128'd1);
        chk("err_after_hdr", {127'd0, err_frame}, {127'd0, m_err});
        for (int k = 0; k < 4; k++) begin
            w = $urandom;
            if (d31 && k == sel) w[31] = 1'b1;
            push(w, bub);
            if (ok) m_rows[3-k] = w;
            chk("frame_data", FrameData, model_data());
            if (k < 3) chk("busy_mid", {127'd0, busy}, 128'd1);
        end
        if (ok) begin
            for (int c = 0; c < 2; c++) begin
                chk("strobe_on", {108'd0, FrameStrobe}, {108'd0, onehot(idx)});
                chk("sready_strobe", {127'd0, s_ready}, 128'd0);
                chk("data_frozen", FrameData, model_data());
                @(posedge CLK);
                #1;
            end
            if (m_done != 16'hFFFF) m_done = m_done + 16'd1;
        end
        chk("strobe_off", {108'd0, FrameStrobe}, 128'd0);
        chk("busy_end", {127'd0, busy}, 128'd0);
        chk("sready_idle", {127'd0, s_ready}, 128'd1);
        chk("frames_done", {112'd0, frames_done}, {112'd0, m_done});
        chk("err_end", {127'd0, err_frame}, {127'd0, m_err});
        chk("data_end", FrameData, model_data());
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_data"}, FrameData, 128'd0);
        chk({tag, "_strobe"}, {108'd0, FrameStrobe}, 128'd0);
        chk({tag, "_busy"}, {127'd0, busy}, 128'd0);
        chk({tag, "_err"}, {127'd0, err_frame}, 128'd0);
        chk({tag, "_done"}, {112'd0, frames_done}, 128'd0);
        chk({tag, "_sready"}, {127'd0, s_ready}, 128'd0);
    endtask

    initial begin
        logic [31:0] hdr;
        reset   = 1'b1;
        s_valid = 1'b0;
        s_data  = '0;
        model_reset();
        repeat (3) @(posedge CLK);
        #1;
        check_reset_state("reset");
        reset = 1'b0;
        #1;
        chk("sready_release", {127'd0, s_ready}, 128'd1);

        frame(32'h8000_0003, 1'b0, 1'b0);
        frame(32'h8500_0001, 1'b0, 1'b0);
        frame(32'h8000_0000 | 32'($urandom_range(0, 19)), 1'b0, 1'b0);
        frame(32'h8000_0017, 1'b0, 1'b0);
        frame(32'h8000_0013, 1'b0, 1'b0);

        push(32'h1234_5678, 1'b0);
        chk("nonheader_busy", {127'd0, busy}, 128'd0);
        chk("nonheader_err", {127'd0, err_frame}, {127'd0, m_err});

        frame(32'h8000_0007, 1'b1, 1'b1);

        for (int i = 0; i < 8; i++) begin
            hdr = $urandom;
            hdr[31] = 1'b1;
            hdr[30:24] = 7'($urandom_range(0, 2));
            hdr[4:0] = 5'($urandom_range(0, 31));
            frame(hdr, 1'($urandom_range(0, 1)), 1'b1);
        end

        push(32'h8000_0002, 1'b0);
        push($urandom, 1'b0);
        push($urandom, 1'b0);
        reset = 1'b1;
        @(posedge CLK);
        #1;
        check_reset_state("rst_load");
        reset = 1'b0;
        model_reset();
        frame(32'h8000_0004, 1'b0, 1'b0);

        push(32'h8000_0005, 1'b0);
        for (int k = 0; k < 4; k++) push($urandom, 1'b0);
        chk("strobe_before_rst", {108'd0, FrameStrobe}, {108'd0, onehot(5)});
        reset = 1'b1;
        @(posedge CLK);
        #1;
        check_reset_state("rst_strobe");
        reset = 1'b0;
        model_reset();
        frame(32'h8000_0009, 1'b1, 1'b0);

        @(negedge CLK);
        force dut.frames_done_q = 16'hFFFE;
        @(posedge CLK);
        #1;
        release dut.frames_done_q;
        m_done = 16'hFFFE;
        chk("done_preset", {112'd0, frames_done}, {112'd0, m_done});
        for (int i = 0; i < 3; i++) frame(32'h8000_0000 | 32'($urandom_range(0, 19)), 1'b0, 1'b0);
        chk("done_saturated", {112'd0, frames_done}, 128'h0000_FFFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
